// File: rtl/quadrant_histogram.sv
// Per-quadrant sample histogram over batches of N samples; each finished batch
// is snapshotted and offered downstream over the dav_/rfd handshake.
module quadrant_histogram #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         done,
    input  logic [1:0]   quad,
    input  logic         rfd,
    output logic         dav_,
    output logic [W-1:0] Q0,
    output logic [W-1:0] Q1,
    output logic [W-1:0] Q2,
    output logic [W-1:0] Q3,
    output logic [1:0]   maxq,
    output logic         ovr
);

    // state   | meaning
    // IDLE    | no snapshot pending, dav_=1
    // WAITRFD | snapshot held, waiting for rfd=1 before asserting dav_
    // OFFER   | dav_=0, waiting for rfd=0 to end the transfer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITRFD = 2'd1,
        OFFER   = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] cnt_q [4];
    logic [W-1:0] cnt_d [4];
    logic [W-1:0] sc_q;
    logic [W-1:0] sc_d;
    logic         done_prev_q;
    logic         sample;
    logic         batch;
    logic [1:0]   max_d;

    always_comb begin
        sample = done & ~done_prev_q;
        batch  = sample && (sc_q == W'(N - 1));
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i] + W'(sample && (quad == 2'(i)));
        end
        sc_d = sc_q + W'(sample);
        // strict compare keeps the lowest index on ties
        max_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_d[i] > cnt_d[max_d]) max_d = 2'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            dav_        <= 1'b1;
            Q0          <= '0;
            Q1          <= '0;
            Q2          <= '0;
            Q3          <= '0;
            maxq        <= 2'd0;
            ovr         <= 1'b0;
            sc_q        <= '0;
            done_prev_q <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            done_prev_q <= done;
            if (batch) begin
                sc_q <= '0;
                for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            end else begin
                sc_q <= sc_d;
                for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            end

            case (state_q)
                IDLE: begin
                    dav_ <= 1'b1;
                    if (batch) begin
                        Q0      <= cnt_d[0];
                        Q1      <= cnt_d[1];
                        Q2      <= cnt_d[2];
                        Q3      <= cnt_d[3];
                        maxq    <= max_d;
                        state_q <= WAITRFD;
                    end
                end
                WAITRFD: begin
                    if (batch) ovr <= 1'b1;
                    if (rfd) begin
                        dav_    <= 1'b0;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (batch) ovr <= 1'b1;
                    if (!rfd) begin
                        dav_    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    dav_    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
